// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             bit_out,
    output logic             bit_valid
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] ra, rb, res;
    logic [WIDTH-1:0] ra_n, rb_n, res_n, diff_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             brw, brw_n, bout_n, done_n, bit_out_n, bit_valid_n;
    logic             d, nb;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    assign d  = ra[0] ^ rb[0] ^ brw;
    assign nb = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw);

    // busy is a pure decode of the state flop, so it is still registered.
    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ra        <= '0;
            rb        <= '0;
            res       <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            done      <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ra        <= ra_n;
            rb        <= rb_n;
            res       <= res_n;
            brw       <= brw_n;
            cnt       <= cnt_n;
            diff      <= diff_n;
            bout      <= bout_n;
            done      <= done_n;
            bit_out   <= bit_out_n;
            bit_valid <= bit_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        ra_n        = ra;
        rb_n        = rb;
        res_n       = res;
        brw_n       = brw;
        cnt_n       = cnt;
        diff_n      = diff;
        bout_n      = bout;
        done_n      = 1'b0;
        bit_out_n   = bit_out;
        bit_valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ra_n    = a;
                    rb_n    = b;
                    brw_n   = bin;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                ra_n              = ra >> 1;
                rb_n              = rb >> 1;
                // Shift-then-set keeps this valid for WIDTH=1 as well.
                res_n             = res >> 1;
                res_n[WIDTH-1]    = d;
                brw_n             = nb;
                cnt_n             = cnt + 1'b1;
                bit_out_n         = d;
                bit_valid_n       = 1'b1;
                if (cnt == LAST) begin
                    diff_n  = res_n;
                    bout_n  = nb;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, bin, busy, done, bout, bit_out, bit_valid;
    logic [7:0] a, b, diff;
    logic       start1, bin1, busy1, done1, bout1, bit_out1, bit_valid1;
    logic [0:0] a1, b1, diff1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout),
        .bit_out(bit_out), .bit_valid(bit_valid));

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1),
        .bit_out(bit_out1), .bit_valid(bit_valid1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 operation with latency, busy, bit stream and result checks.
    task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                        input logic [7:0] ed, input logic eb, input string nm);
        int n;
        int nbits;
        logic [7:0] bits;
        logic busy_bad;
        @(negedge clk);
        a = ai; b = bi; bin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; nbits = 0; bits = '0; busy_bad = 1'b0;
        while (!done && n < 30) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (bit_valid === 1'b1) begin
                if (nbits < 8) bits[nbits] = bit_out;
                nbits++;
            end
            @(negedge clk);
            n++;
        end
        if (bit_valid === 1'b1) begin
            if (nbits < 8) bits[nbits] = bit_out;
            nbits++;
        end
        chk({nm, " latency"}, n, 8);
        chk({nm, " busy during shift"}, busy_bad, 0);
        chk({nm, " busy in done cycle"}, busy, 0);
        chk({nm, " diff"}, diff, ed);
        chk({nm, " bout"}, bout, eb);
        chk({nm, " bit count"}, nbits, 8);
        chk({nm, " bit stream"}, bits, ed);
        @(negedge clk);
        chk({nm, " done one cycle"}, done, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int pulses;
        logic [8:0] m;
        logic [1:0] m1;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset bit_valid", bit_valid, 0);
        chk("reset bit_out", bit_out, 0);
        chk("reset w1 busy/done", {busy1, done1, diff1, bout1}, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
                 $sformatf("vec%0d", i));

        // Start held extra cycles and operands disturbed mid-operation.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 1) a = 8'h00;
            if (i == 3) start = 1'b0;
            if (done === 1'b1) pulses++;
        end
        chk("held start pulses", pulses, 1);
        chk("held start diff", diff, 8'h1E);
        chk("held start bout", bout, 0);

        // Back-to-back: new start in the done cycle.
        @(negedge clk);
        a = 8'hFF; b = 8'h0F; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30) begin @(negedge clk); n++; end
        chk("b2b first diff", diff, 8'hF0);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("b2b accepted busy", busy, 1);
        while (!done && n < 30) begin @(negedge clk); n++; end
        chk("b2b spacing", n, 9);
        chk("b2b diff", diff, 8'h7F);
        chk("b2b bout", bout, 0);

        // Reset mid-operation.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset busy", busy, 0);
        chk("midreset diff", diff, 0);
        chk("midreset bout", bout, 0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("midreset no done", pulses, 0);
        run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "after reset");

        // Random sweep at WIDTH=8 against a 9-bit reference.
        for (int i = 0; i < 500; i++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            m = {1'b0, ra} - {1'b0, rb} - {8'b0, rc};
            run8(ra, rb, rc, m[7:0], m[8], $sformatf("rand8 %0d", i));
        end

        // Random sweep at WIDTH=1.
        for (int i = 0; i < 500; i++) begin
            logic ra, rb, rc;
            ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
            m1 = {1'b0, ra} - {1'b0, rb} - {1'b0, rc};
            @(negedge clk);
            a1 = ra; b1 = rb; bin1 = rc; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            chk("w1 busy after accept", {busy1, done1}, 2'b10);
            @(negedge clk);
            chk("w1 done", {busy1, done1}, 2'b01);
            chk("w1 result", {bout1, diff1}, m1);
            chk("w1 bit_out", {bit_valid1, bit_out1}, {1'b1, m1[0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor. It computes diff = a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop. It is the inverse-operation companion to the team's combinational full-adder datapath. Used where area matters more than latency; a start/done handshake frames each operation. A per-bit serial monitor output is provided for pin-level observation.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepting edge
b  input  WIDTH  subtrahend; captured on accepting edge
bin  input  1  borrow-in; captured on accepting edge
busy  output  1  high while state is SHIFT
done  output  1  one-cycle pulse; diff/bout valid from this cycle
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  final borrow-out (1 when a < b + bin, unsigned)
bit_out  output  1  difference bit produced by the most recent shift
bit_valid  output  1  high for the cycle after each shift edge

Behaviour:
- Reset, with rst high at an edge:
  - state=IDLE
  - busy, done, bit_out, bit_valid = 0
  - diff = 0, bout = 0
  - internal shift registers, borrow flop and counter cleared
  - rst has priority over all other inputs.
- States: IDLE, SHIFT. All outputs are registered.
- IDLE:
  - start=1 at edge E0: ra<=a, rb<=b, brw<=bin, cnt<=0, state<=SHIFT.
  - start=0: hold.
- SHIFT, edges E1..E_WIDTH (one bit per edge):
  - d = ra[0] ^ rb[0] ^ brw
  - nb = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw)
  - ra, rb shift right by one.
  - Result shift register shifts right with d entering the MSB.
  - brw<=nb, cnt<=cnt+1
  - bit_out<=d, bit_valid<=1. bit_valid is 0 after any edge that performs no shift.
- Final shift, when cnt==WIDTH-1 at the edge:
  - diff <= final result register
  - bout <= nb
  - done <= 1 for exactly one cycle
  - state <= IDLE
- Latency:
  - done is high in the cycle following E_WIDTH, i.e. WIDTH cycles after the accepting edge.
  - busy is high from after E0 through the cycle before done.
  - busy and done are never high together.
- Throughput: start may be asserted in the done cycle. That start is accepted (state is already IDLE), giving back-to-back operations every WIDTH+1 cycles.
- start while busy: ignored. Operands are not re-captured, no queuing, no error flag.
- a, b, bin changing during SHIFT: no effect on the in-flight operation.
- diff and bout hold their last completed value until the next done. They are not cleared on start.
- WIDTH=1: single shift edge; done one cycle after E0.
- Reset mid-operation aborts the operation: no done, diff/bout return to 0.
- Unsigned semantics only. bout is the unsigned underflow indicator; no signed overflow output.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0. done exactly 8 cycles after the start edge. bit_out sequence LSB-first 0,1,1,1,1,0,0,0, with bit_valid high 8 consecutive cycles.
2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
3. Start pulse held 3 extra cycles, plus operands changed mid-operation (a=0x5A, b=0x3C, then a=0x00) -> single operation only, result 0x1E, one done pulse.
4. Back-to-back: second start (a=0x80, b=0x01, bin=0) asserted during the first operation's done cycle -> second done 9 cycles after the first done, diff=0x7F, bout=0.
5. rst asserted 4 cycles into an operation -> busy=0 and diff=0 next cycle, no done pulse. A new start after reset completes normally.
6. Random sweep, 1000 operations at WIDTH=8 and WIDTH=1 -> diff/bout match the reference model {bout,diff} = {1'b0,a} - b - bin in 9-bit arithmetic. busy/done timing as specified on every operation.
